// File: rtl/upd1771c_feed_pkg.sv
// upd1771c_feed_pkg: sequencer state encoding and hold/gap counter sizing
package upd1771c_feed_pkg;

    typedef enum logic [1:0] {IDLE, ALIGN, HOLD, GAP} state_e;

    function automatic int cnt_w(input int h, input int g, input int p);
        int m;
        m = (h > g) ? h : g;
        m = (m > p) ? m : p;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/upd1771c_feed_fifo.sv
// upd1771c_feed_fifo: synchronous FIFO with a registered occupancy count
module upd1771c_feed_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign level = level_q;
    assign full  = level_q == LW'(DEPTH);
    assign empty = level_q == '0;

endmodule

// File: rtl/upd1771c_cmd_feeder.sv
// upd1771c_cmd_feeder: FIFO-buffered, PHI2-aligned command byte sequencer for the uPD1771C PA port
module upd1771c_cmd_feeder
    import upd1771c_feed_pkg::*;
#(
    parameter int            DW          = 8,
    parameter int            DEPTH       = 16,
    parameter int            HOLD_CYC    = 8,
    parameter int            GAP_CYC     = 72,
    parameter int            PKT_GAP_CYC = 256,
    parameter logic [DW-1:0] IDLE_VAL    = '0,
    parameter bit            RETURN_IDLE = 1'b0,
    localparam int           LW          = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          CKEN,
    input  logic          PHI2,
    input  logic          WR_VALID,
    input  logic [DW-1:0] WR_DATA,
    input  logic          WR_LAST,
    output logic          WR_READY,
    output logic [DW-1:0] PA_O,
    output logic          PA_STB,
    output logic          BUSY,
    output logic [LW-1:0] LEVEL,
    output logic          OVF,
    input  logic          CLR_OVF
);

    localparam int CW = cnt_w(HOLD_CYC, GAP_CYC, PKT_GAP_CYC);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (HOLD_CYC == 0 || GAP_CYC == 0 || PKT_GAP_CYC == 0) begin : g_bad_cyc
        $error("HOLD_CYC, GAP_CYC and PKT_GAP_CYC must be non-zero");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] pa_q, pa_d;
    logic          last_q, last_d, stb_q, stb_d, ovf_q, ovf_d;
    logic [DW:0]   head;
    logic          push, pop, full, empty;

    assign push = WR_VALID & ~full;

    upd1771c_feed_fifo #(.W(DW + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RES),
        .push  (push),
        .pop   (pop),
        .din   ({WR_LAST, WR_DATA}),
        .dout  (head),
        .level (LEVEL),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pa_d    = pa_q;
        last_d  = last_q;
        stb_d   = stb_q;
        pop     = 1'b0;
        ovf_d   = (WR_VALID & full) | (ovf_q & ~CLR_OVF);
        case (state_q)
            IDLE: state_d = empty ? IDLE : ALIGN;
            ALIGN: if (PHI2 && CKEN && !empty) begin
                pop            = 1'b1;
                state_d        = HOLD;
                cnt_d          = CW'(HOLD_CYC - 1);
                {last_d, pa_d} = head;
                stb_d          = 1'b1;
            end
            HOLD: if (CKEN) begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    stb_d   = 1'b0;
                    cnt_d   = last_q ? CW'(PKT_GAP_CYC - 1) : CW'(GAP_CYC - 1);
                    pa_d    = RETURN_IDLE ? IDLE_VAL : pa_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: if (CKEN) begin
                if (cnt_q == '0) state_d = empty ? IDLE : ALIGN;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pa_q    <= IDLE_VAL;
            last_q  <= 1'b0;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pa_q    <= pa_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign WR_READY = ~full;
    assign PA_O     = pa_q;
    assign PA_STB   = stb_q;
    assign OVF      = ovf_q;
    assign BUSY     = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_upd1771c_cmd_feeder.sv
// tb_upd1771c_cmd_feeder: directed checks of timing, framing, overflow, reset and FIFO wrap
module tb_upd1771c_cmd_feeder;

    logic       CLK, RES, CKEN, PHI2, WR_VALID, WR_LAST, CLR_OVF;
    logic [7:0] WR_DATA, PA_O;
    logic       WR_READY, PA_STB, BUSY, OVF;
    logic [4:0] LEVEL;

    int n_chk, n_fail, cyc, cken_div, n, a, b;
    bit phi_en, phi_man;

    upd1771c_cmd_feeder dut (
        .CLK      (CLK),
        .RES      (RES),
        .CKEN     (CKEN),
        .PHI2     (PHI2),
        .WR_VALID (WR_VALID),
        .WR_DATA  (WR_DATA),
        .WR_LAST  (WR_LAST),
        .WR_READY (WR_READY),
        .PA_O     (PA_O),
        .PA_STB   (PA_STB),
        .BUSY     (BUSY),
        .LEVEL    (LEVEL),
        .OVF      (OVF),
        .CLR_OVF  (CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // PHI2 fires every 4th clock and CKEN every cken_div-th clock unless driven by hand
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (!phi_man) PHI2 = phi_en && (cyc % 4 == 0);
        CKEN = (cyc % cken_div == 0);
    endtask

    task automatic wr(input logic [7:0] d, input logic l);
        WR_VALID = 1'b1;
        WR_DATA  = d;
        WR_LAST  = l;
        tick();
        WR_VALID = 1'b0;
        WR_LAST  = 1'b0;
    endtask

    task automatic wait_stb(input logic v, input int budget, output int cnt);
        cnt = 0;
        while (PA_STB !== v && cnt < budget) begin
            tick();
            cnt++;
        end
        if (PA_STB !== v) check("stb_timeout", PA_STB, v);
    endtask

    task automatic wait_idle(input int budget, output int cnt);
        cnt = 0;
        while (BUSY !== 1'b0 && cnt < budget) begin
            tick();
            cnt++;
        end
        if (BUSY !== 1'b0) check("busy_timeout", BUSY, 0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; cken_div = 1;
        phi_en = 1'b1; phi_man = 1'b0;
        RES = 1'b1; CKEN = 1'b1; PHI2 = 1'b0; WR_VALID = 1'b0;
        WR_DATA = '0; WR_LAST = 1'b0; CLR_OVF = 1'b0;
        tick();
        tick();
        check("rst_pa_o", PA_O, 8'h00);
        check("rst_stb", PA_STB, 0);
        check("rst_busy", BUSY, 0);
        check("rst_level", LEVEL, 0);
        check("rst_ovf", OVF, 0);
        check("rst_ready", WR_READY, 1);
        RES = 1'b0;
        tick();

        // single byte: 8 hold clocks, 72 gap clocks, PA_O keeps the byte
        wr(8'h09, 1'b0);
        check("t1_level", LEVEL, 1);
        check("t1_busy", BUSY, 1);
        check("t1_pa_pre", PA_O, 8'h00);
        wait_stb(1'b1, 50, n);
        check("t1_pa", PA_O, 8'h09);
        wait_stb(1'b0, 50, n);
        check("t1_hold", n, 8);
        wait_idle(200, n);
        check("t1_gap", n, 72);
        check("t1_pa_keep", PA_O, 8'h09);

        // packet framing: 84 = 8 + 72 + 4 align, 268 = 8 + 256 + 4 align
        wr(8'h01, 1'b0);
        wr(8'h02, 1'b0);
        wr(8'h03, 1'b1);
        wr(8'h04, 1'b0);
        wait_stb(1'b1, 50, n);
        check("t2_pa0", PA_O, 8'h01);
        for (int k = 1; k < 4; k++) begin
            wait_stb(1'b0, 50, a);
            wait_stb(1'b1, 400, b);
            check($sformatf("t2_space%0d", k), a + b, (k == 3) ? 268 : 84);
            check($sformatf("t2_pa%0d", k), PA_O, 8'h01 + k);
        end
        wait_stb(1'b0, 50, n);
        wait_idle(200, n);

        // overflow with the sequencer stalled in ALIGN
        phi_en = 1'b0;
        PHI2   = 1'b0;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("t3_ready%0d", i), WR_READY, i < 16);
            wr(8'h10 + 8'(i), 1'b0);
            check($sformatf("t3_ovf%0d", i), OVF, i == 16);
        end
        check("t3_level", LEVEL, 16);
        WR_VALID = 1'b1;
        CLR_OVF  = 1'b1;
        tick();
        WR_VALID = 1'b0;
        check("t3_set_wins", OVF, 1);
        tick();
        CLR_OVF = 1'b0;
        check("t3_clr", OVF, 0);
        check("t3_level_hold", LEVEL, 16);
        phi_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_stb(1'b1, 400, n);
            check($sformatf("t3_drain%0d", k), PA_O, 8'h10 + 8'(k));
            wait_stb(1'b0, 50, n);
        end
        wait_idle(200, n);
        check("t3_empty", LEVEL, 0);

        // CKEN one clock in six stretches hold and gap sixfold
        cken_div = 6;
        wr(8'h5A, 1'b0);
        wait_stb(1'b1, 200, n);
        check("t4_pa", PA_O, 8'h5A);
        wait_stb(1'b0, 200, n);
        check("t4_hold", n, 48);
        wait_idle(1000, n);
        check("t4_gap", n, 432);
        cken_div = 1;

        // reset in the middle of a hold with five bytes queued
        phi_en = 1'b0;
        PHI2   = 1'b0;
        for (int i = 0; i < 6; i++) wr(8'h61 + 8'(i), 1'b0);
        phi_en = 1'b1;
        wait_stb(1'b1, 50, n);
        tick();
        tick();
        check("t5_level", LEVEL, 5);
        check("t5_stb", PA_STB, 1);
        check("t5_pa", PA_O, 8'h61);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        check("t5_rst_stb", PA_STB, 0);
        check("t5_rst_pa", PA_O, 8'h00);
        check("t5_rst_level", LEVEL, 0);
        check("t5_rst_busy", BUSY, 0);
        check("t5_rst_ready", WR_READY, 1);

        // push and pop together at LEVEL=1, then order across the pointer wrap
        phi_man = 1'b1;
        PHI2    = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
        check("t6_full", LEVEL, 16);
        check("t6_ready", WR_READY, 0);
        PHI2 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            wait_stb(1'b1, 200, n);
            check($sformatf("t6_order%0d", k), PA_O, 8'h40 + 8'(k));
            wait_stb(1'b0, 50, n);
        end
        repeat (72) tick();
        check("t6_pre_stb", PA_STB, 0);
        check("t6_pre_level", LEVEL, 1);
        wr(8'h50, 1'b0);
        check("t6_pp_level", LEVEL, 1);
        check("t6_pp_stb", PA_STB, 1);
        check("t6_pp_pa", PA_O, 8'h4F);
        for (int i = 1; i < 4; i++) wr(8'h50 + 8'(i), 1'b0);
        check("t6_level4", LEVEL, 4);
        for (int k = 0; k < 4; k++) begin
            wait_stb(1'b0, 50, n);
            wait_stb(1'b1, 200, n);
            check($sformatf("t6_wrap%0d", k), PA_O, 8'h50 + 8'(k));
        end
        wait_stb(1'b0, 50, n);
        wait_idle(200, n);
        check("t6_end_level", LEVEL, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/upd1771c_cmd_feeder.md
Name: upd1771c_cmd_feeder

Overview:
- Synthesizable host-side command sequencer for the uPD1771C sound chip.
- Buffers command bytes from the SCV CPU-side bus in a FIFO, then presents each byte on the chip's PA input. Each presentation is aligned to the chip's PHI2 phase, held for a fixed number of chip-clock enables, then followed by an inter-byte gap.
- Adds packet framing (longer gap after a packet's last byte), overflow reporting and a configurable idle value. This replaces ad-hoc single-byte pokes.

Parameters:
- DW, 8, data width of a command word and of PA_O.
- DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.
- HOLD_CYC, 8, CKEN-qualified cycles each byte is driven with PA_STB high.
- GAP_CYC, 72, CKEN-qualified cycles between bytes of the same packet.
- PKT_GAP_CYC, 256, CKEN-qualified cycles after a byte tagged last.
- IDLE_VAL, 8'h00, PA_O value after reset.
- RETURN_IDLE, 0, if 1 PA_O returns to IDLE_VAL at end of hold; if 0 PA_O keeps the last byte.

Ports:
- CLK  in  1  system clock.
- RES  in  1  synchronous reset, active-high.
- CKEN  in  1  chip clock enable; all hold and gap counters advance only when CKEN=1.
- PHI2  in  1  chip PHI2 phase strobe, used for alignment.
- WR_VALID  in  1  write request.
- WR_DATA  in  DW  command byte.
- WR_LAST  in  1  byte ends a packet.
- WR_READY  out  1  FIFO not full.
- PA_O  out  DW  byte driven to the chip PA input.
- PA_STB  out  1  high while the current byte is in its hold window.
- BUSY  out  1  FIFO non-empty or state not IDLE.
- LEVEL  out  $clog2(DEPTH+1)  FIFO occupancy.
- OVF  out  1  sticky overflow flag.
- CLR_OVF  in  1  clears OVF.

Behaviour:
- Reset values: PA_O=IDLE_VAL, PA_STB=0, BUSY=0, LEVEL=0, OVF=0, WR_READY=1, state=IDLE, counters=0. RES mid-operation aborts any hold or gap and discards FIFO contents.
- Push: occurs when WR_VALID & WR_READY. WR_READY=(LEVEL!=DEPTH) and is independent of WR_VALID and of the pop.
- Overflow: WR_VALID & ~WR_READY drops the byte and sets OVF on the next edge.
  - CLR_OVF clears OVF.
  - If CLR_OVF and an overflow occur in the same cycle, set wins.
- Pop and push in the same cycle: LEVEL is unchanged. Pointers wrap modulo DEPTH.
- IDLE: move to ALIGN when LEVEL!=0. A byte pushed into an empty FIFO at edge t gives ALIGN at t+1.
- ALIGN: when PHI2 & CKEN, pop the head on that edge and move to HOLD.
  - From the next cycle: PA_O=data, PA_STB=1; latch the tag last_q=WR_LAST of the entry.
  - Pushes arriving after that edge do not affect the byte in flight.
- HOLD: counter starts at HOLD_CYC-1 and decrements on CKEN. On CKEN with counter=0, move to GAP.
  - PA_STB is high for exactly HOLD_CYC CKEN cycles; with CKEN=1 constantly that is HOLD_CYC clocks.
  - On exit PA_STB=0; PA_O=IDLE_VAL if RETURN_IDLE=1.
- GAP: counter loads (last_q ? PKT_GAP_CYC : GAP_CYC)-1 and decrements on CKEN.
  - At zero: move to ALIGN if LEVEL!=0, else IDLE.
  - A zero gap parameter is illegal (elaboration assertion).
- CKEN=0: freezes every state and counter; FIFO push and pop still work (pop only in ALIGN, which needs CKEN anyway).
- BUSY falls the cycle the FSM enters IDLE with LEVEL=0.
- Counter widths: $clog2(max(HOLD_CYC,GAP_CYC,PKT_GAP_CYC)).

Decomposition:
- Package upd1771c_feed_pkg: state enum (IDLE, ALIGN, HOLD, GAP) and the counter-width function.
- One sub-module, upd1771c_feed_fifo: synchronous FIFO with DW+1 bits per entry (data + last), DEPTH entries, registered LEVEL, and full/empty derived from LEVEL.
- Top module: FSM, counters, OVF and output registers.

Test Plan:
- Reset, then single write 8'h09 (last=0), CKEN=1, PHI2 pulsing every 4 clocks.
  - PA_O=8'h09 on the cycle after the first PHI2 in ALIGN.
  - PA_STB high exactly 8 clocks, then 72 gap clocks.
  - BUSY falls at the end of the gap; PA_O stays 8'h09 (RETURN_IDLE=0).
- Packet 8'h01, 8'h02, 8'h03(last) followed by 8'h04.
  - PA_STB rising edges are spaced 8+72+ALIGN wait between 01→02 and 02→03.
  - Spacing is 8+256+ALIGN wait between 03→04.
- 17 back-to-back writes with DEPTH=16 and the FSM stalled by PHI2=0.
  - WR_READY drops after 16 writes; LEVEL=16; 17th byte dropped; OVF=1.
  - Same-cycle CLR_OVF+overflow leaves OVF=1.
- CKEN toggling 1-in-6 during HOLD.
  - PA_STB lasts 48 clocks (8 enables); the gap stretches ×6 likewise.
- RES asserted mid-HOLD with LEVEL=5.
  - Next cycle: PA_STB=0, PA_O=IDLE_VAL, LEVEL=0, BUSY=0, WR_READY=1.
- Push and pop in the same cycle at LEVEL=1.
  - LEVEL stays 1; byte order is preserved across a pointer wrap after 20 writes.
